// File: rtl/muldiv_seq_if.sv
// Request/result bundle between the execute stage and the HI/LO
// multiply/divide sequencer.
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       alucontrol;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic             flush;
    logic             hilo_read;
    logic             busy;
    logic             stall;
    logic             done;
    logic             divzero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, alucontrol, srca, srcb, flush, hilo_read,
        input  busy, stall, done, divzero, hi, lo
    );

    modport slave (
        input  start, alucontrol, srca, srcb, flush, hilo_read,
        output busy, stall, done, divzero, hi, lo
    );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative shift-add multiply / restoring divide owning HI/LO.
// Define MULDIV_SIGNED_EN for two's complement operands.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input logic         clk,
    input logic         reset,
    muldiv_seq_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic             op_div_q;
    logic             neg_lo_q;
    logic             neg_hi_q;
    logic             busy_q;
    logic             done_q;
    logic             divz_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] wh_q;
    logic [WIDTH-1:0] wl_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic             is_mul;
    logic             is_div;
    logic             accept;
    logic             sa;
    logic             sb;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rs;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] wh_d;
    logic [WIDTH-1:0] wl_d;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] hi_d;
    logic [WIDTH-1:0] lo_d;

    assign is_mul = (bus.alucontrol == 4'b1010);
    assign is_div = (bus.alucontrol == 4'b1011);
    assign accept = bus.start & ~bus.flush & (is_mul | is_div);

`ifdef MULDIV_SIGNED_EN
    assign sa = bus.srca[WIDTH-1];
    assign sb = bus.srcb[WIDTH-1];
`else
    assign sa = 1'b0;
    assign sb = 1'b0;
`endif

    assign a_mag = sa ? -bus.srca : bus.srca;
    assign b_mag = sb ? -bus.srcb : bus.srcb;

    // One iteration of either algorithm, plus sign-corrected final result
    always_comb begin
        sum  = {1'b0, wh_q} + (wl_q[0] ? {1'b0, b_q} : '0);
        rs   = {wh_q, wl_q[WIDTH-1]};
        diff = rs - {1'b0, b_q};
        wh_d = wh_q;
        wl_d = wl_q;
        if (op_div_q) begin
            if (!diff[WIDTH]) begin
                wh_d = diff[WIDTH-1:0];
                wl_d = {wl_q[WIDTH-2:0], 1'b1};
            end else begin
                wh_d = rs[WIDTH-1:0];
                wl_d = {wl_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            wh_d = sum[WIDTH:1];
            wl_d = {sum[0], wl_q[WIDTH-1:1]};
        end
        prod = neg_lo_q ? -{wh_d, wl_d} : {wh_d, wl_d};
        if (op_div_q) begin
            hi_d = neg_hi_q ? -wh_d : wh_d;
            lo_d = neg_lo_q ? -wl_d : wl_d;
        end else begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
        end
    end

    // Sequencer FSM: capture, iterate, commit HI/LO on entry to DONE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            divz_q   <= 1'b0;
            b_q      <= '0;
            wh_q     <= '0;
            wl_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    divz_q <= 1'b0;
                    if (accept) begin
                        busy_q <= 1'b1;
                        if (is_div && bus.srcb == '0) begin
                            state_q <= DONE;
                            hi_q    <= bus.srca;
                            lo_q    <= '1;
                            done_q  <= 1'b1;
                            divz_q  <= 1'b1;
                        end else begin
                            state_q  <= RUN;
                            cnt_q    <= CW'(WIDTH - 1);
                            op_div_q <= is_div;
                            neg_lo_q <= sa ^ sb;
                            neg_hi_q <= sa;
                            wh_q     <= '0;
                            b_q      <= is_div ? b_mag : a_mag;
                            wl_q     <= is_div ? a_mag : b_mag;
                        end
                    end
                end
                RUN: begin
                    if (bus.flush) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        wh_q  <= wh_d;
                        wl_q  <= wl_d;
                        cnt_q <= cnt_q - CW'(1);
                        if (cnt_q == '0) begin
                            state_q <= DONE;
                            hi_q    <= hi_d;
                            lo_q    <= lo_d;
                            done_q  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    divz_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    divz_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.stall   = busy_q & bus.hilo_read;
    assign bus.done    = done_q;
    assign bus.divzero = divz_q;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: vector table, scoreboard queue,
// and hand sequences for reset, flush, stall and ignored starts.
module tb_muldiv_seq;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    muldiv_seq_if #(.WIDTH(W)) bus();
    muldiv_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        div;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    vec_t tbl[$];
    vec_t sb_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t model(logic div, logic [31:0] a, logic [31:0] b);
        vec_t v;
        logic [63:0] p;
        v.div = div; v.a = a; v.b = b; v.dz = 1'b0;
        if (div && b == 0) begin
            v.hi = a; v.lo = 32'hFFFF_FFFF; v.dz = 1'b1;
        end else if (div) begin
`ifdef MULDIV_SIGNED_EN
            v.lo = $signed(a) / $signed(b);
            v.hi = $signed(a) % $signed(b);
`else
            v.lo = a / b;
            v.hi = a % b;
`endif
        end else begin
`ifdef MULDIV_SIGNED_EN
            p = longint'($signed(a)) * longint'($signed(b));
`else
            p = 64'(a) * 64'(b);
`endif
            v.hi = p[63:32];
            v.lo = p[31:0];
        end
        return v;
    endfunction

    task automatic do_op(vec_t v, logic hr);
        int cyc;
        int exp_lat;
        int bad_busy;
        int bad_stall;
        vec_t e;
        @(negedge clk);
        bus.start      = 1'b1;
        bus.alucontrol = v.div ? 4'b1011 : 4'b1010;
        bus.srca       = v.a;
        bus.srcb       = v.b;
        bus.hilo_read  = hr;
        sb_q.push_back(v);
        exp_lat = (v.div && v.b == 0) ? 1 : W + 1;
        @(negedge clk);
        bus.start = 1'b0;
        bad_busy  = 0;
        bad_stall = 0;
        for (cyc = 1; cyc <= W + 8; cyc++) begin
            if (bus.busy !== 1'b1) bad_busy++;
            if (bus.stall !== hr) bad_stall++;
            if (bus.done === 1'b1) break;
            @(negedge clk);
        end
        check("latency", 64'(cyc), 64'(exp_lat));
        check("busy_during_op", 64'(bad_busy), 64'd0);
        check("stall_during_op", 64'(bad_stall), 64'd0);
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            if (bus.done === 1'b1) begin
                check("hi", 64'(bus.hi), 64'(e.hi));
                check("lo", 64'(bus.lo), 64'(e.lo));
                check("divzero", 64'(bus.divzero), 64'(e.dz));
            end
        end
        @(negedge clk);
        check("post_idle", {61'd0, bus.busy, bus.stall, bus.done}, 64'd0);
        bus.hilo_read = 1'b0;
    endtask

    task automatic add(logic div, logic [31:0] a, logic [31:0] b,
                       logic [31:0] hi, logic [31:0] lo, logic dz);
        vec_t v;
        v.div = div; v.a = a; v.b = b; v.hi = hi; v.lo = lo; v.dz = dz;
        tbl.push_back(v);
    endtask

    initial begin
        vec_t v;
        int dones;
        logic [31:0] ra;
        logic [31:0] rb;

        bus.start      = 1'b0;
        bus.alucontrol = 4'b0000;
        bus.srca       = '0;
        bus.srcb       = '0;
        bus.flush      = 1'b0;
        bus.hilo_read  = 1'b1;

        add(1'b0, 32'd7, 32'd6, 32'h0, 32'h2A, 1'b0);
`ifdef MULDIV_SIGNED_EN
        add(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0);
        add(1'b0, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        add(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
`else
        add(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b0);
        add(1'b0, 32'hFFFF_FFF9, 32'd3, 32'h2, 32'hFFFF_FFEB, 1'b0);
        add(1'b1, 32'hFFFF_FFF9, 32'd2, 32'h1, 32'h7FFF_FFFC, 1'b0);
`endif
        add(1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        add(1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
        add(1'b1, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'hFFFF_FFFF, 1'b0);
        add(1'b1, 32'd3, 32'd10, 32'd3, 32'd0, 1'b0);
        add(1'b0, 32'd0, 32'h1234, 32'd0, 32'd0, 1'b0);
        add(1'b1, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (ra == 32'h8000_0000) ra = 32'd1;
            tbl.push_back(model(i[0], ra, rb));
        end

        repeat (2) @(negedge clk);
        check("reset_state",
              {bus.busy, bus.stall, bus.done, bus.divzero, bus.hi, bus.lo},
              64'd0);
        reset = 1'b0;
        bus.hilo_read = 1'b0;
        @(negedge clk);

        foreach (tbl[i]) do_op(tbl[i], (i == 0) ? 1'b1 : 1'b0);

        bus.start      = 1'b1;
        bus.alucontrol = 4'b0010;
        bus.srca       = 32'd9;
        bus.srcb       = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        check("ignored_code", 64'(bus.busy), 64'd0);

        bus.start      = 1'b1;
        bus.alucontrol = 4'b1010;
        bus.flush      = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("flush_beats_start", 64'(bus.busy), 64'd0);

        v = model(1'b0, 32'd7, 32'd6);
        do_op(v, 1'b0);
        @(negedge clk);
        bus.start      = 1'b1;
        bus.alucontrol = 4'b1011;
        bus.srca       = 32'd100;
        bus.srcb       = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_idle", 64'(bus.busy), 64'd0);
        dones = 0;
        for (int i = 0; i < W + 8; i++) begin
            if (bus.done === 1'b1) dones++;
            @(negedge clk);
        end
        check("flush_no_done", 64'(dones), 64'd0);
        check("flush_hilo_kept", {bus.hi, bus.lo}, 64'h0000_0000_0000_002A);

        bus.start      = 1'b1;
        bus.alucontrol = 4'b1010;
        bus.srca       = 32'h1234_5678;
        bus.srcb       = 32'h0BAD_F00D;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        check("mid_run_busy", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("reset_mid_run",
              {bus.busy, bus.done, bus.divzero, 29'd0, bus.hi | bus.lo},
              64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("after_reset_idle", 64'(bus.busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
